cordic_arbiter: RTL and testbench
=================================

Name: cordic_arbiter

Overview:
- Shares one cordic core between NumReq requesters.
- Per-requester valid/ready operand ports; round-robin grant.
- Latches the granted operands, pulses the core start, waits for done, and returns the tagged result on a single valid/ready response port.
- A watchdog flags a core that never completes. Sits between the client blocks and the single cordic instance.

Parameters:
- Width, 16, operand/result bit width (matches the core).
- NumReq, 4, number of requesters (2..8).
- IdWidth, 2, width of requester index; must be >= $clog2(NumReq).
- Timeout, 64, maximum cycles to wait for core done after start (>= 2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NumReq  request valid, one bit per requester
- req_ready_o  out  NumReq  one-hot accept pulse
- req_x_i  in  NumReq*Width  packed x0 operands; requester k at [k*Width +: Width]
- req_y_i  in  NumReq*Width  packed y0 operands, same packing
- req_z_i  in  NumReq*Width  packed z0 operands, same packing
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result consumer ready
- rsp_id_o  out  IdWidth  index of the requester that owns the result
- rsp_x_o  out  Width  captured xn
- rsp_y_o  out  Width  captured yn
- rsp_z_o  out  Width  captured zn
- rsp_err_o  out  1  1 = watchdog timeout; result fields are 0
- core_start_o  out  1  start pulse to the core
- core_x0_o  out  Width  core x operand
- core_y0_o  out  Width  core y operand
- core_z0_o  out  Width  core z operand
- core_xn_i  in  Width  core x result
- core_yn_i  in  Width  core y result
- core_zn_i  in  Width  core z result
- core_done_i  in  1  core done tick

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high.
- Reset values:
  - All outputs 0. FSM in IDLE.
  - RR pointer last = NumReq-1, so requester 0 has first priority.
  - Operand, result and id registers 0.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid_i is set, grant g = first set bit scanning last+1, last+2, ... modulo NumReq.
  - In the same cycle: req_ready_o[g]=1 (combinational from the registered state and req_valid_i). Latch req_x/y/z[g] into the operand registers and g into the id register. Go to LAUNCH.
  - Otherwise stay; req_ready_o=0.
- LAUNCH:
  - core_start_o=1 for exactly this cycle.
  - Clear the watchdog counter. Go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If core_done_i=1: capture core_xn/yn/zn into the result registers, rsp_err_o<=0, go to RESP.
  - Else, if the counter reaches Timeout-1: result registers <=0, rsp_err_o<=1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - rsp_valid_o=1. rsp_id/x/y/z/err_o are held stable until the handshake.
  - On rsp_valid_o & rsp_ready_i: last <= id, go to IDLE.
  - A new request can be accepted in the cycle after the handshake, never in the same cycle.
- Core operand drive: core_x0/y0/z0_o are driven continuously from the operand registers. They are stable from LAUNCH through WAIT.
- Handshake rules:
  - req_ready_o is at most one-hot and only asserted in IDLE.
  - A requester may drop valid before it is granted; a withdrawn request is simply not selected.
  - Operands are sampled only in the grant cycle.
- Latency:
  - Grant at cycle c, core_start_o at c+1.
  - If core_done_i arrives at cycle d, rsp_valid_o is high from d+1.
  - Minimum accept-to-accept spacing is 4 cycles plus core latency plus response stall.
- Ignored inputs:
  - core_done_i outside WAIT is ignored; no capture, no state change.
  - rsp_ready_i outside RESP is ignored.
- Fairness: a continuously valid requester is served within NumReq grants.
- Counter width: $clog2(Timeout). It is never compared past Timeout-1, so it does not wrap.
- Reset mid-operation (any state): returns to IDLE with the reset values. An in-flight result is discarded and no response is issued.

Test Plan:
- Single request: req_valid_i=4'b0100, x=16'h26DD, y=0, z=16'h2183, core model done 16 cycles after start -> req_ready_o=4'b0100 for one cycle; core_start_o one cycle later; rsp_valid_o 1 cycle after done with rsp_id_o=2 and rsp_x/y/z_o equal to the model outputs; rsp_err_o=0.
- Round-robin: all four valid continuously, rsp_ready_i=1 -> grant order 0,1,2,3,0 with rsp_id_o in the same order; no requester granted twice before the others.
- Backpressure: rsp_ready_i=0 for 10 cycles during RESP -> rsp_valid_o and all rsp fields stable; req_ready_o stays 0 despite pending requests; grant occurs the cycle after rsp_ready_i=1.
- Timeout: Timeout=8, core_done_i never asserted -> rsp_valid_o 8 cycles after LAUNCH with rsp_err_o=1, rsp_x/y/z_o=0; the next request is served normally.
- Spurious done and reset: core_done_i pulsed in IDLE -> no rsp_valid_o. rst_i asserted in WAIT -> all outputs 0 next cycle, no response; requester 0 wins the next grant over requester 3.

Source files
------------

// File: rtl/cordic_arbiter.sv
// Round-robin front end that time-shares a single cordic core between NumReq clients.
// Grants one operand set, launches the core, then returns a tagged result or a watchdog error.
module cordic_arbiter #(
  parameter int Width   = 16,
  parameter int NumReq  = 4,
  parameter int IdWidth = 2,
  parameter int Timeout = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_valid_i,
  output logic [NumReq-1:0]         req_ready_o,
  input  logic [NumReq*Width-1:0]   req_x_i,
  input  logic [NumReq*Width-1:0]   req_y_i,
  input  logic [NumReq*Width-1:0]   req_z_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [IdWidth-1:0]        rsp_id_o,
  output logic [Width-1:0]          rsp_x_o,
  output logic [Width-1:0]          rsp_y_o,
  output logic [Width-1:0]          rsp_z_o,
  output logic                      rsp_err_o,
  output logic                      core_start_o,
  output logic [Width-1:0]          core_x0_o,
  output logic [Width-1:0]          core_y0_o,
  output logic [Width-1:0]          core_z0_o,
  input  logic [Width-1:0]          core_xn_i,
  input  logic [Width-1:0]          core_yn_i,
  input  logic [Width-1:0]          core_zn_i,
  input  logic                      core_done_i
);

  localparam int CntW = $clog2(Timeout);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t             r_state, w_stateNext;
  logic [IdWidth-1:0] r_last, r_id;
  logic [Width-1:0]   r_opX, r_opY, r_opZ;
  logic [Width-1:0]   r_resX, r_resY, r_resZ;
  logic               r_err;
  logic [CntW-1:0]    r_cnt;

  logic               w_hiFound, w_anyValid;
  logic [IdWidth-1:0] w_hiIdx, w_loIdx, w_grant;
  logic [Width-1:0]   w_selX, w_selY, w_selZ;
  logic [CntW-1:0]    w_cntInc;
  logic               w_timeout;

  // Prefer the lowest valid index above the last winner, else wrap to the lowest valid index.
  always_comb begin
    w_hiFound  = 1'b0;
    w_anyValid = 1'b0;
    w_hiIdx    = '0;
    w_loIdx    = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        w_anyValid = 1'b1;
        w_loIdx    = IdWidth'(k);
        if (k > int'(r_last)) begin
          w_hiFound = 1'b1;
          w_hiIdx   = IdWidth'(k);
        end
      end
    end
    w_grant = w_hiFound ? w_hiIdx : w_loIdx;
  end

  always_comb begin
    w_selX = '0;
    w_selY = '0;
    w_selZ = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (w_grant == IdWidth'(k)) begin
        w_selX = req_x_i[k*Width +: Width];
        w_selY = req_y_i[k*Width +: Width];
        w_selZ = req_z_i[k*Width +: Width];
      end
    end
  end

  // The counter only ever reaches Timeout-1, so it never wraps.
  assign w_cntInc  = r_cnt + CntW'(1);
  assign w_timeout = (w_cntInc == CntW'(Timeout - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_anyValid) w_stateNext = LAUNCH;
      LAUNCH:  w_stateNext = WAIT;
      WAIT:    if (core_done_i || w_timeout) w_stateNext = RESP;
      RESP:    if (rsp_ready_i) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    core_start_o = 1'b0;
    rsp_valid_o  = 1'b0;
    case (r_state)
      IDLE: begin
        for (int k = 0; k < NumReq; k++) begin
          req_ready_o[k] = !rst_i && w_anyValid && (w_grant == IdWidth'(k));
        end
      end
      LAUNCH:  core_start_o = 1'b1;
      RESP:    rsp_valid_o  = 1'b1;
      default: ;
    endcase
  end

  // A completing done beats a timeout that lands on the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= IdWidth'(NumReq - 1);
      r_id   <= '0;
      r_opX  <= '0;
      r_opY  <= '0;
      r_opZ  <= '0;
      r_resX <= '0;
      r_resY <= '0;
      r_resZ <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyValid) begin
            r_opX <= w_selX;
            r_opY <= w_selY;
            r_opZ <= w_selZ;
            r_id  <= w_grant;
          end
        end
        LAUNCH: r_cnt <= '0;
        WAIT: begin
          r_cnt <= w_cntInc;
          if (core_done_i) begin
            r_resX <= core_xn_i;
            r_resY <= core_yn_i;
            r_resZ <= core_zn_i;
            r_err  <= 1'b0;
          end else if (w_timeout) begin
            r_resX <= '0;
            r_resY <= '0;
            r_resZ <= '0;
            r_err  <= 1'b1;
          end
        end
        RESP: if (rsp_ready_i) r_last <= r_id;
        default: ;
      endcase
    end
  end

  assign rsp_id_o  = r_id;
  assign rsp_x_o   = r_resX;
  assign rsp_y_o   = r_resY;
  assign rsp_z_o   = r_resZ;
  assign rsp_err_o = r_err;
  assign core_x0_o = r_opX;
  assign core_y0_o = r_opY;
  assign core_z0_o = r_opZ;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: a fixed-latency core model answers starts, and every
// grant pushes the expected tagged response that is popped at the response handshake.
module tb_cordic_arbiter;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TO  = 64;
  localparam int LAT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*W-1:0]  req_x_i, req_y_i, req_z_i;
  logic            rsp_valid_o, rsp_ready_i;
  logic [IW-1:0]   rsp_id_o;
  logic [W-1:0]    rsp_x_o, rsp_y_o, rsp_z_o;
  logic            rsp_err_o, core_start_o;
  logic [W-1:0]    core_x0_o, core_y0_o, core_z0_o;
  logic [W-1:0]    core_xn_i, core_yn_i, core_zn_i;
  logic            core_done_i;

  logic [W-1:0] opX [N];
  logic [W-1:0] opY [N];
  logic [W-1:0] opZ [N];

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  x, y, z;
    logic          err;
  } rsp_t;
  rsp_t          sb[$];
  logic [IW-1:0] rspLog[$];

  int passCount = 0, checkCount = 0;
  int cyc = 0, grantCyc = 0, startCyc = 0, doneCyc = 0, rspCyc = 0, hsCyc = 0;
  int rspCount = 0, expLast = N - 1, coreCnt = 0;
  logic coreEnable = 1'b1, modelDone = 1'b0, forceDone = 1'b0, prevRspValid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_x_i[k*W +: W] = opX[k];
      req_y_i[k*W +: W] = opY[k];
      req_z_i[k*W +: W] = opZ[k];
    end
  end

  assign core_done_i = modelDone | forceDone;

  cordic_arbiter #(.Width(W), .NumReq(N), .IdWidth(IW), .Timeout(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_x_i(req_x_i), .req_y_i(req_y_i), .req_z_i(req_z_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_x_o(rsp_x_o), .rsp_y_o(rsp_y_o), .rsp_z_o(rsp_z_o), .rsp_err_o(rsp_err_o),
    .core_start_o(core_start_o),
    .core_x0_o(core_x0_o), .core_y0_o(core_y0_o), .core_z0_o(core_z0_o),
    .core_xn_i(core_xn_i), .core_yn_i(core_yn_i), .core_zn_i(core_zn_i),
    .core_done_i(core_done_i)
  );

  function automatic logic [W-1:0] fX(input logic [W-1:0] v); return v + 16'h1234; endfunction
  function automatic logic [W-1:0] fY(input logic [W-1:0] v); return v ^ 16'h5A5A; endfunction
  function automatic logic [W-1:0] fZ(input logic [W-1:0] v); return v - 16'h0101; endfunction

  function automatic int rrModel(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last + i) % N;
      if (v[k]) return k;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Core model: done pulses LAT cycles after the start cycle unless disabled.
  always @(negedge clk) begin
    modelDone = 1'b0;
    if (coreCnt > 0) begin
      coreCnt--;
      if (coreCnt == 0) begin
        modelDone = 1'b1;
        doneCyc   = cyc;
      end
    end
    if (core_start_o) begin
      startCyc  = cyc;
      coreCnt   = coreEnable ? LAT : 0;
      core_xn_i = fX(core_x0_o);
      core_yn_i = fY(core_y0_o);
      core_zn_i = fZ(core_z0_o);
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    int   g;
    if (rst) begin
      sb.delete();
      expLast      = N - 1;
      prevRspValid = 1'b0;
    end else begin
      if (req_ready_o != '0) begin
        g = rrModel(req_valid_i, expLast);
        checkOutput("grant_onehot", req_ready_o, N'(1) << g);
        e.id  = IW'(g);
        e.err = !coreEnable;
        e.x   = coreEnable ? fX(opX[g]) : '0;
        e.y   = coreEnable ? fY(opY[g]) : '0;
        e.z   = coreEnable ? fZ(opZ[g]) : '0;
        sb.push_back(e);
        grantCyc = cyc;
      end
      if (rsp_valid_o && !prevRspValid) rspCyc = cyc;
      prevRspValid = rsp_valid_o;
      if (rsp_valid_o && rsp_ready_i) begin
        checkOutput("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("rsp_id", rsp_id_o, e.id);
          checkOutput("rsp_x", rsp_x_o, e.x);
          checkOutput("rsp_y", rsp_y_o, e.y);
          checkOutput("rsp_z", rsp_z_o, e.z);
          checkOutput("rsp_err", rsp_err_o, e.err);
          expLast = int'(e.id);
        end
        rspLog.push_back(rsp_id_o);
        rspCount++;
        hsCyc = cyc;
      end
    end
  end

  task automatic sampleEdge();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v);
    @(posedge clk);
    #1 req_valid_i = v;
  endtask

  task automatic waitGrant(input string tag, input int budget);
    int n = 0;
    do begin
      sampleEdge();
      n++;
    end while (req_ready_o == '0 && n < budget);
    checkOutput({"grant_wait_", tag}, req_ready_o != '0, 1);
  endtask

  task automatic waitRsp(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && rspCount < target; i++) sampleEdge();
    checkOutput({"rsp_wait_", tag}, rspCount, target);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (sb.size() != 0 || rsp_valid_o); i++) sampleEdge();
    checkOutput({"drain_", tag}, sb.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, core_start_o}, 0);
    checkOutput({tag, "_rsp"}, {rsp_x_o, rsp_y_o, rsp_z_o}, 0);
    checkOutput({tag, "_core"}, {core_x0_o, core_y0_o, core_z0_o}, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int base;
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    core_xn_i = '0; core_yn_i = '0; core_zn_i = '0;
    for (int k = 0; k < N; k++) begin
      opX[k] = 16'h1000 * W'(k + 1) + 16'h0011;
      opY[k] = 16'h0200 * W'(k + 1) + 16'h0003;
      opZ[k] = 16'h0030 * W'(k + 1) + 16'h0700;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sampleEdge();
    checkAllZero("reset");

    $display("[TB] single request");
    opX[2] = 16'h26DD; opY[2] = 16'h0000; opZ[2] = 16'h2183;
    applyStimulus(4'b0100);
    waitGrant("single", 20);
    checkOutput("single_grant", req_ready_o, 4'b0100);
    applyStimulus(4'b0000);
    sampleEdge();
    checkOutput("single_ready_pulse", req_ready_o, 0);
    checkOutput("single_start", core_start_o, 1);
    checkOutput("single_start_lat", cyc, grantCyc + 1);
    checkOutput("single_core_x0", core_x0_o, 16'h26DD);
    sampleEdge();
    checkOutput("single_start_once", core_start_o, 0);
    waitRsp("single", 1, 100);
    checkOutput("single_rsp_lat", rspCyc, doneCyc + 1);
    drain("single", 50);

    $display("[TB] round robin");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    base = rspLog.size();
    applyStimulus(4'b1111);
    waitRsp("rr", rspCount + 5, 300);
    applyStimulus(4'b0000);
    for (int i = 0; i < 5; i++) begin
      if (base + i < rspLog.size()) checkOutput($sformatf("rr_order%0d", i), rspLog[base + i], order[i]);
      else checkOutput($sformatf("rr_missing%0d", i), rspLog.size(), base + i + 1);
    end
    drain("rr", 100);

    $display("[TB] backpressure");
    rsp_ready_i = 1'b0;
    applyStimulus(4'b0010);
    waitGrant("bp", 20);
    applyStimulus(4'b1001);
    for (int i = 0; i < 100 && !rsp_valid_o; i++) sampleEdge();
    checkOutput("bp_rsp_valid_seen", rsp_valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      sampleEdge();
      checkOutput("bp_valid_hold", rsp_valid_o, 1);
      checkOutput("bp_no_grant", req_ready_o, 0);
      if (sb.size() != 0) begin
        checkOutput("bp_id_hold", rsp_id_o, sb[0].id);
        checkOutput("bp_data_hold", {rsp_x_o, rsp_y_o, rsp_z_o}, {sb[0].x, sb[0].y, sb[0].z});
      end
    end
    @(posedge clk); #1 rsp_ready_i = 1'b1;
    sampleEdge();
    sampleEdge();
    checkOutput("bp_grant_next", grantCyc, hsCyc + 1);
    checkOutput("bp_grant_oh", req_ready_o, 4'b1000);
    applyStimulus(4'b0000);
    drain("bp", 100);

    $display("[TB] watchdog timeout");
    coreEnable = 1'b0;
    applyStimulus(4'b0001);
    waitGrant("to", 20);
    applyStimulus(4'b0000);
    waitRsp("to", rspCount + 1, TO + 30);
    checkOutput("to_lat", rspCyc, startCyc + TO);
    coreEnable = 1'b1;
    drain("to", 20);
    applyStimulus(4'b0100);
    waitGrant("after_to", 20);
    applyStimulus(4'b0000);
    waitRsp("after_to", rspCount + 1, 100);
    drain("after_to", 20);

    $display("[TB] spurious done and reset in WAIT");
    base = rspCount;
    @(posedge clk); #1 forceDone = 1'b1;
    @(posedge clk); #1 forceDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sampleEdge();
      checkOutput("spur_no_rsp", rsp_valid_o, 0);
      checkOutput("spur_no_start", core_start_o, 0);
    end
    applyStimulus(4'b0010);
    waitGrant("rstw", 20);
    applyStimulus(4'b0000);
    repeat (3) sampleEdge();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sampleEdge();
    checkAllZero("rst_wait");
    repeat (30) sampleEdge();
    checkOutput("rst_no_rsp", rspCount, base);
    applyStimulus(4'b1001);
    waitGrant("rst_prio", 20);
    checkOutput("rst_prio", req_ready_o, 4'b0001);
    applyStimulus(4'b0000);
    waitRsp("rst_prio", base + 1, 100);
    drain("final", 50);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
